// File: rtl/alpha_sequencer_if.sv
// Strobe/request inputs and coefficient/status outputs of alpha_sequencer.
// The design sits on the slave modport; the driver of select_b sits on master.
interface alpha_sequencer_if;
  logic       enable_3M;
  logic       select_b;
  logic [4:0] alpha_sequence;
  logic       busy;
  logic       channel_b;
  logic       done;

  modport master (
    output enable_3M,
    output select_b,
    input  alpha_sequence,
    input  busy,
    input  channel_b,
    input  done
  );

  modport slave (
    input  enable_3M,
    input  select_b,
    output alpha_sequence,
    output busy,
    output channel_b,
    output done
  );
endinterface

// File: rtl/alpha_sequencer.sv
// Crossfade coefficient generator: ramps alpha between 0 (channel a) and 16 (channel b)
// at a programmable rate, with a minimum settled dwell and mid-ramp reversal.
module alpha_sequencer #(
  parameter int unsigned STEP_DIV = 4,
  parameter int unsigned MIN_HOLD = 64
) (
  input logic              clk,
  input logic              reset,
  alpha_sequencer_if.slave bus
);

  localparam int unsigned DivW  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned HoldW = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
  localparam logic [DivW-1:0]  DivLast = DivW'(STEP_DIV - 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MIN_HOLD);

  typedef enum logic [1:0] {StIdleA, StRampUp, StIdleB, StRampDown} state_e;

  state_e           state_q, state_d;
  logic [4:0]       alpha_q, alpha_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdleA;
      alpha_q <= 5'd0;
      div_q   <= '0;
      hold_q  <= HoldMax;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      alpha_q <= alpha_d;
      div_q   <= div_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    alpha_d = alpha_q;
    div_d   = div_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    if (bus.enable_3M) begin
      unique case (state_q)
        StIdleA, StIdleB: begin
          if (hold_q != HoldMax) hold_d = hold_q + HoldW'(1);
          if (hold_q == HoldMax) begin
            if (state_q == StIdleA && bus.select_b) begin
              state_d = StRampUp;
              div_d   = '0;
            end else if (state_q == StIdleB && !bus.select_b) begin
              state_d = StRampDown;
              div_d   = '0;
            end
          end
        end
        StRampUp: begin
          if (!bus.select_b) begin
            // Reversing at the endpoint we are heading back to settles immediately.
            if (alpha_q == 5'd0) begin
              state_d = StIdleA;
              done_d  = 1'b1;
              hold_d  = '0;
            end else begin
              state_d = StRampDown;
            end
            div_d = '0;
          end else if (div_q == DivLast) begin
            alpha_d = alpha_q + 5'd1;
            div_d   = '0;
            if (alpha_q == 5'd15) begin
              state_d = StIdleB;
              done_d  = 1'b1;
              hold_d  = '0;
            end
          end else begin
            div_d = div_q + DivW'(1);
          end
        end
        StRampDown: begin
          if (bus.select_b) begin
            if (alpha_q == 5'd16) begin
              state_d = StIdleB;
              done_d  = 1'b1;
              hold_d  = '0;
            end else begin
              state_d = StRampUp;
            end
            div_d = '0;
          end else if (div_q == DivLast) begin
            alpha_d = alpha_q - 5'd1;
            div_d   = '0;
            if (alpha_q == 5'd1) begin
              state_d = StIdleA;
              done_d  = 1'b1;
              hold_d  = '0;
            end
          end else begin
            div_d = div_q + DivW'(1);
          end
        end
        default: state_d = StIdleA;
      endcase
    end
  end

  always_comb begin
    bus.alpha_sequence = alpha_q;
    bus.busy           = (state_q == StRampUp) || (state_q == StRampDown);
    bus.channel_b      = (state_q == StIdleB);
    bus.done           = done_q;
  end

endmodule

// File: tb/tb_alpha_sequencer.sv
// Randomized and directed bench for alpha_sequencer against a per-strobe behavioural
// model that tracks alpha as an integer and the ramp as a signed direction.
module tb_alpha_sequencer;
  localparam int unsigned STEP_DIV = 4;
  localparam int unsigned MIN_HOLD = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  // Model state: dir is 0 when settled, +1/-1 while ramping.
  int m_alpha, m_dir, m_div, m_hold, m_done;

  alpha_sequencer_if bus ();

  alpha_sequencer #(
    .STEP_DIV(STEP_DIV),
    .MIN_HOLD(MIN_HOLD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic en, input logic sel, input logic rst);
    int want_dir, target;
    if (rst) begin
      m_alpha = 0; m_dir = 0; m_div = 0; m_hold = MIN_HOLD; m_done = 0;
      return;
    end
    m_done = 0;
    if (!en) return;
    target   = sel ? 16 : 0;
    want_dir = sel ? 1 : -1;
    if (m_dir == 0) begin
      if (m_hold == MIN_HOLD && m_alpha != target) begin
        m_dir = want_dir;
        m_div = 0;
      end
      if (m_hold < MIN_HOLD) m_hold++;
    end else if (want_dir != m_dir) begin
      m_div = 0;
      if (m_alpha == target) begin
        m_dir = 0; m_done = 1; m_hold = 0;
      end else begin
        m_dir = want_dir;
      end
    end else if (m_div == STEP_DIV - 1) begin
      m_alpha += m_dir;
      m_div = 0;
      if (m_alpha == 0 || m_alpha == 16) begin
        m_dir = 0; m_done = 1; m_hold = 0;
      end
    end else begin
      m_div++;
    end
  endtask

  task automatic tick(input logic en, input logic sel, input logic rst);
    bus.enable_3M = en;
    bus.select_b  = sel;
    reset         = rst;
    @(posedge clk);
    model_step(en, sel, rst);
    #1;
    check("alpha", 32'(bus.alpha_sequence), m_alpha);
    check("busy", 32'(bus.busy), (m_dir != 0) ? 1 : 0);
    check("channel_b", 32'(bus.channel_b), (m_dir == 0 && m_alpha == 16) ? 1 : 0);
    check("done", 32'(bus.done), m_done);
  endtask

  // One strobe followed by three idle clocks.
  task automatic strobes(input int n, input logic sel);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, sel, 1'b0);
      for (int j = 0; j < 3; j++) tick(1'b0, sel, 1'b0);
    end
  endtask

  initial begin
    bus.enable_3M = 1'b0;
    bus.select_b  = 1'b0;
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    check("rst_alpha", 32'(bus.alpha_sequence), 0);
    check("rst_busy", 32'(bus.busy), 0);

    strobes(100, 1'b0);
    check("idle_a_alpha", 32'(bus.alpha_sequence), 0);

    // Full up-ramp: entry on strobe 1, alpha=k on strobe 1+4k.
    tick(1'b1, 1'b1, 1'b0);
    check("ramp_entry_busy", 32'(bus.busy), 1);
    check("ramp_entry_alpha", 32'(bus.alpha_sequence), 0);
    for (int j = 0; j < 3; j++) tick(1'b0, 1'b1, 1'b0);
    strobes(63, 1'b1);
    check("strobe64_alpha", 32'(bus.alpha_sequence), 15);
    tick(1'b1, 1'b1, 1'b0);
    check("strobe65_alpha", 32'(bus.alpha_sequence), 16);
    check("strobe65_done", 32'(bus.done), 1);
    check("strobe65_chb", 32'(bus.channel_b), 1);
    tick(1'b0, 1'b1, 1'b0);
    check("done_one_clk", 32'(bus.done), 0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);

    // Dwell: 8 strobes to saturate hold, ramp-down on the 9th.
    strobes(2, 1'b1);
    strobes(1, 1'b0);
    strobes(1, 1'b1);
    strobes(4, 1'b0);
    check("dwell_alpha", 32'(bus.alpha_sequence), 16);
    check("dwell_busy", 32'(bus.busy), 0);
    tick(1'b1, 1'b0, 1'b0);
    check("dwell_release_busy", 32'(bus.busy), 1);
    for (int j = 0; j < 3; j++) tick(1'b0, 1'b0, 1'b0);

    // Partial ramp-down then reversal back up to 16.
    strobes(10, 1'b0);
    strobes(20, 1'b1);

    // Strobe gating: toggling select_b without strobes changes nothing.
    for (int i = 0; i < 200; i++) tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    check("gated_alpha", 32'(bus.alpha_sequence), m_alpha);

    // Settle in channel a, then ramp up and reset at alpha=9.
    strobes(90, 1'b0);
    for (int i = 0; i < 400 && !(m_alpha == 9 && m_dir != 0); i++) strobes(1, 1'b1);
    check("reached_9", 32'(bus.alpha_sequence), 9);
    tick(1'b0, 1'b1, 1'b1);
    check("midreset_alpha", 32'(bus.alpha_sequence), 0);
    check("midreset_done", 32'(bus.done), 0);
    tick(1'b1, 1'b1, 1'b0);
    check("post_reset_ramp", 32'(bus.busy), 1);

    // Random phase: sparse strobes, slow select changes, rare resets.
    begin
      logic sel;
      sel = 1'b0;
      for (int i = 0; i < 6000; i++) begin
        if ($urandom_range(0, 59) == 0) sel = ~sel;
        tick(1'($urandom_range(0, 1)), ($urandom_range(0, 199) == 0) ? ~sel : sel,
             1'($urandom_range(0, 999) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
